// File: rtl/rocketcpu_wb_intercon_pkg.sv
// Shared types and constants for the single-master Wishbone interconnect.
// Holds the FSM state encoding, the default error data word and the error-counter helper.
package rocketcpu_wb_intercon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } wb_state_e;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          ERR_CNT_W    = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rocketcpu_wb_decode.sv
// Combinational address decoder: slave i hits when (adr & MASK_i) == BASE_i.
// When several regions overlap, the lowest slave index wins.
module rocketcpu_wb_decode #(
    parameter int                           NUM_SLAVES = 8,
    parameter int                           IDX_W      = 3,
    parameter logic [32*NUM_SLAVES-1:0]     SLV_BASE   = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]     SLV_MASK   = {NUM_SLAVES{32'h0}}
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan from the top down so the lowest matching index is the last one written.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rocketcpu_wb_intercon.sv
// Single-master Wishbone interconnect: registered slave select, auto-ack for ack-less
// slaves, a watchdog that turns a silent slave into an error response, and error logging.
module rocketcpu_wb_intercon
    import rocketcpu_wb_intercon_pkg::*;
#(
    parameter int                       NUM_SLAVES = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES-1:0]    AUTO_ACK   = {NUM_SLAVES{1'b0}},
    parameter int                       TIMEOUT    = 255,
    parameter logic [31:0]              ERR_DATA   = DEF_ERR_DATA
) (
    input  logic                     i_wb_clk,
    input  logic                     reset,
    input  logic [31:0]              i_wb_adr,
    input  logic [31:0]              i_wb_dat,
    input  logic [3:0]               i_wb_sel,
    input  logic                     i_wb_we,
    input  logic                     i_wb_cyc,
    output logic [31:0]              o_wb_rdt,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    output logic [31:0]              o_s_adr,
    output logic [31:0]              o_s_dat,
    output logic [3:0]               o_s_sel,
    output logic                     o_s_we,
    output logic [NUM_SLAVES-1:0]    o_s_cyc,
    input  logic [32*NUM_SLAVES-1:0] i_s_rdt,
    input  logic [NUM_SLAVES-1:0]    i_s_ack,
    output logic [ERR_CNT_W-1:0]     o_err_count,
    output logic [31:0]              o_err_adr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    wb_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_SLAVES-1:0]  scyc_q, scyc_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [31:0]            rdt_q, rdt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [31:0]            err_adr_q, err_adr_d;

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   ack_eff;
    logic [31:0]            sel_rdt;
    logic                   log_err;

    rocketcpu_wb_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .adr (i_wb_adr),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign o_s_adr = i_wb_adr;
    assign o_s_dat = i_wb_dat;
    assign o_s_sel = i_wb_sel;
    assign o_s_we  = i_wb_we;

    assign ack_eff = AUTO_ACK[idx_q] | i_s_ack[idx_q];
    assign sel_rdt = i_s_rdt[32*idx_q +: 32];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        scyc_d    = scyc_q;
        ack_d     = 1'b0;
        err_d     = err_q;
        rdt_d     = rdt_q;
        timer_d   = timer_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        log_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc) begin
                    if (dec_hit) begin
                        idx_d          = dec_idx;
                        scyc_d         = '0;
                        scyc_d[dec_idx] = 1'b1;
                        timer_d        = '0;
                        err_d          = 1'b0;
                        state_d        = ST_ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        rdt_d   = ERR_DATA;
                        ack_d   = 1'b1;
                        log_err = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                // A slave ack in the last watchdog cycle still counts as a normal response.
                if (ack_eff) begin
                    rdt_d   = sel_rdt;
                    scyc_d  = '0;
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    scyc_d  = '0;
                    err_d   = 1'b1;
                    rdt_d   = ERR_DATA;
                    ack_d   = 1'b1;
                    log_err = 1'b1;
                    state_d = ST_RESP;
                end else if (!i_wb_cyc) begin
                    scyc_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                scyc_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (log_err) begin
            err_adr_d = i_wb_adr;
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge i_wb_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            scyc_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdt_q     <= '0;
            timer_q   <= '0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            scyc_q    <= scyc_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdt_q     <= rdt_d;
            timer_q   <= timer_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign o_s_cyc     = scyc_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_err    = err_q;
    assign o_wb_rdt    = rdt_q;
    assign o_err_count = err_cnt_q;
    assign o_err_adr   = err_adr_q;

endmodule
